regfile_write_sequencer: RTL and testbench
==========================================

// Module: regfile_write_sequencer
// PURPOSE
//  Shares the register file's single write port (write_enable/in_addr/in_data) among NUM_REQ writeback requesters.
//  Arbitration is round-robin, with a valid/ready handshake per requester.
//  Also sequences a full-file clear (writes CLEAR_VAL to every address) on command.
//  Sits between the execution/load writeback paths and register_file; all rf_* outputs are registered.
// PARAMETERS
//  NUM_REQ    4      number of write requesters (2..8)
//  ADDR_W     5      register address width (2**ADDR_W registers)
//  DATA_W     32     register data width
//  CLEAR_VAL  0      value written to each register during a clear sequence
// PORTS
//  clk              in   1                 clock, rising edge
//  reset            in   1                 asynchronous, active-low reset
//  req_valid        in   NUM_REQ           requester i has a write pending
//  req_addr         in   NUM_REQ*ADDR_W    requester i target address, slice [i*ADDR_W +: ADDR_W]
//  req_data         in   NUM_REQ*DATA_W    requester i write data, slice [i*DATA_W +: DATA_W]
//  req_ready        out  NUM_REQ           one-hot grant; transfer when valid & ready
//  hold             in   1                 freeze: no grants, clear counter paused
//  clear_start      in   1                 pulse: begin clear sequence
//  clear_busy       out  1                 high in CLEAR and DONE states
//  clear_done       out  1                 one-cycle pulse coincident with final clear strobe
//  rf_write_enable  out  1                 to register_file write_enable
//  rf_in_addr       out  ADDR_W            to register_file in_addr
//  rf_in_data       out  DATA_W            to register_file in_data
//  rf_grant_id      out  clog2(NUM_REQ)    source of the current strobe (0 during clear)
// BEHAVIOUR
//  Reset (reset=0, async): state=ARB, rr_ptr=0, clr_cnt=0.
//   All outputs 0: rf_write_enable, rf_in_addr, rf_in_data, rf_grant_id, clear_busy, clear_done.
//  FSM states: ARB -> CLEAR -> DONE -> ARB.
//  ARB:
//   - If clear_start && !hold: go to CLEAR, clr_cnt=0, no grant this cycle. clear_start has priority over requests.
//   - Else if !hold: grant the first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     req_ready (combinational) is asserted for that index only.
//   - On grant g: rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
//  Latency: handshake in cycle N -> rf_write_enable=1 with that addr/data/id during cycle N+1 only.
//   The register file captures it at the end of cycle N+1.
//  No grant in a cycle -> rf_write_enable=0 next cycle; rf_in_addr/rf_in_data hold their last values.
//  CLEAR:
//   - Each non-hold cycle loads the output register with (clr_cnt, CLEAR_VAL, id 0), then clr_cnt++.
//   - When clr_cnt == 2**ADDR_W-1 is issued: go to DONE.
//   - hold pauses the counter and suppresses the strobe.
//   - clear_start is ignored in CLEAR and DONE.
//  DONE: lasts one cycle. clear_done=1 while the last strobe (addr 2**ADDR_W-1) is visible. Next state ARB.
//  No grants in CLEAR or DONE; req_ready=0.
//  Requesters must hold valid/addr/data stable until ready. The block never drops or merges requests.
//  Same-address requests in one cycle: serviced one per cycle in RR order; the later grant wins in the file.
//  Reset mid-clear aborts the sequence: registers already written keep CLEAR_VAL, clear_done never pulses.
//  clr_cnt is ADDR_W bits and wraps naturally; the exit condition is decided on the issue of the max address.
// CONFIGURATION
//  RF_ARB_STATS_EN defined:
//   - Adds out stat_grants [NUM_REQ*16]: per-requester 16-bit grant counters, saturating at 16'hFFFF.
//   - Adds out stat_conflicts [16]: counts ARB cycles with more than one valid request and !hold; saturating.
//   - All counters clear on reset only.
//  RF_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package regfile_arb_pkg.vh:
//   - FSM state encodings ST_ARB=2'd0, ST_CLEAR=2'd1, ST_DONE=2'd2.
//   - Default ADDR_W/DATA_W; STAT_W=16.
//  Sub-module rf_rr_select: combinational round-robin picker.
//   - In: valid vector, rr_ptr. Out: one-hot grant, grant index, any_grant.
//  Top level holds the FSM, rr_ptr, clr_cnt, output register and optional stats counters.
// TESTING
//  1. Reset release, req_valid=0: all outputs 0 for 10 cycles; rr_ptr=0.
//  2. Single write: req 1 valid, addr=2, data=2222.
//     -> req_ready=4'b0010 that cycle; next cycle rf_write_enable=1, rf_in_addr=2, rf_in_data=2222, rf_grant_id=1.
//     -> register_file reads back 2222 at addr 2.
//  3. All 4 valid continuously, addrs 4..7: grants in order 0,1,2,3,0...
//     -> Each requester is granted once per 4 cycles; drop req 2 and the order becomes 0,1,3,0,1,3.
//  4. hold=1 with req 0 valid for 3 cycles: req_ready=0 and rf_write_enable=0 throughout.
//     -> After hold drops, req 0 is granted on the next cycle.
//  5. clear_start after writing 5678 at 2:
//     -> 32 consecutive strobes, addr 0..31, data 0; clear_done=1 with addr 31.
//     -> Reading addr 2 returns 0; a request pending during the clear is granted the cycle after DONE.
//  6. Assert reset at clr_cnt=10: outputs 0 immediately, state ARB.
//     -> A new clear_start restarts from addr 0; with RF_ARB_STATS_EN, counters read 0 after reset.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write sequencer: FSM encodings and default widths.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned STAT_W     = 16;

endpackage

// File: rtl/rf_rr_select.sv
// Combinational round-robin picker: first valid index scanning from rr_ptr upward, wrapping.
module rf_rr_select #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_grant && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Round-robin sharing of the register file write port plus a full-file clear sequencer.
// Optional per-requester grant and conflict counters when RF_ARB_STATS_EN is defined.
module regfile_write_sequencer
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      hold,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_in_addr,
  output logic [DATA_W-1:0]         rf_in_data,
  output logic [ID_W-1:0]           rf_grant_id
`ifdef RF_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_conflicts
`endif
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic              arb_en_c;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]   grant_idx_c;
  logic              any_grant_c;
  logic              we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;
  logic [ID_W-1:0]   id_nx;

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  // clear_start outranks requests, so a starting clear also blocks the grant
  assign arb_en_c  = (state == ST_ARB) && !hold && !clear_start;
  assign req_ready = grant_c;

  rf_rr_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_sel (
    .valid     (req_valid & {NUM_REQ{arb_en_c}}),
    .rr_ptr    (rr_ptr),
    .grant     (grant_c),
    .grant_idx (grant_idx_c),
    .any_grant (any_grant_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_ARB;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Next state and the value to load into the write-port register
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    we_nx      = 1'b0;
    addr_nx    = rf_in_addr;
    data_nx    = rf_in_data;
    id_nx      = rf_grant_id;
    case (state)
      ST_ARB: begin
        if (clear_start && !hold) begin
          state_nx   = ST_CLEAR;
          clr_cnt_nx = '0;
        end else if (any_grant_c) begin
          we_nx   = 1'b1;
          addr_nx = addr_a[grant_idx_c];
          data_nx = data_a[grant_idx_c];
          id_nx   = grant_idx_c;
        end
      end
      ST_CLEAR: begin
        if (!hold) begin
          we_nx      = 1'b1;
          addr_nx    = clr_cnt;
          data_nx    = CLEAR_VAL;
          id_nx      = '0;
          clr_cnt_nx = clr_cnt + 1'b1;
          if (clr_cnt == CNT_MAX) state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_ARB;
      default:  state_nx = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr          <= '0;
      rf_write_enable <= 1'b0;
      rf_in_addr      <= '0;
      rf_in_data      <= '0;
      rf_grant_id     <= '0;
      clear_busy      <= 1'b0;
      clear_done      <= 1'b0;
    end else begin
      if (any_grant_c) begin
        rr_ptr <= (grant_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + 1'b1;
      end
      rf_write_enable <= we_nx;
      rf_in_addr      <= addr_nx;
      rf_in_data      <= data_nx;
      rf_grant_id     <= id_nx;
      clear_busy      <= (state_nx != ST_ARB);
      clear_done      <= (state_nx == ST_DONE);
    end
  end

`ifdef RF_ARB_STATS_EN
  // Saturating counters, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_c[i] && (stat_grants[i*STAT_W +: STAT_W] != '1)) begin
          stat_grants[i*STAT_W +: STAT_W] <= stat_grants[i*STAT_W +: STAT_W] + 1'b1;
        end
      end
      if ((state == ST_ARB) && !hold && ($countones(req_valid) > 1) && (stat_conflicts != '1)) begin
        stat_conflicts <= stat_conflicts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Scoreboard bench for regfile_write_sequencer: a behavioural model predicts each cycle's port output.
module tb_regfile_write_sequencer;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          hold, clear_start;
  logic          clear_busy, clear_done, rf_write_enable;
  logic [AW-1:0] rf_in_addr;
  logic [DW-1:0] rf_in_data;
  logic [1:0]    rf_grant_id;
`ifdef RF_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
  logic [15:0]      stat_conflicts;
`endif

  always #5 clk = ~clk;

  regfile_write_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .hold            (hold),
    .clear_start     (clear_start),
    .clear_busy      (clear_busy),
    .clear_done      (clear_done),
    .rf_write_enable (rf_write_enable),
    .rf_in_addr      (rf_in_addr),
    .rf_in_data      (rf_in_data),
    .rf_grant_id     (rf_grant_id)
`ifdef RF_ARB_STATS_EN
    ,
    .stat_grants     (stat_grants),
    .stat_conflicts  (stat_conflicts)
`endif
  );

  // Register file stand-in fed by the write port
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_in_addr] <= rf_in_data;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  int            m_state;
  int            m_ptr;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [1:0]    m_id;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cnt = 0;
    m_addr = '0; m_data = '0; m_id = '0;
    sb_q.delete();
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One clock: predict, check ready, push expectation, clock, pop and compare
  task automatic cycle(output logic [NR-1:0] er);
    exp_t e;
    int g;
    #2;
    er = '0;
    e.we = 1'b0; e.addr = m_addr; e.data = m_data; e.id = m_id;
    if (m_state == 0) begin
      if (clear_start && !hold) begin
        m_state = 1;
        m_cnt = 0;
      end else if (!hold) begin
        g = -1;
        for (int k = 0; k < NR; k++) if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        if (g >= 0) begin
          er[g] = 1'b1;
          e.we = 1'b1;
          e.addr = req_addr[g*AW +: AW];
          e.data = req_data[g*DW +: DW];
          e.id = 2'(g);
          m_ptr = (g + 1) % NR;
        end
      end
    end else if (m_state == 1) begin
      if (!hold) begin
        e.we = 1'b1; e.addr = AW'(m_cnt); e.data = '0; e.id = '0;
        if (m_cnt == 31) m_state = 2;
        m_cnt++;
      end
    end else begin
      m_state = 0;
    end
    m_addr = e.addr; m_data = e.data; m_id = e.id;
    e.busy = (m_state != 0);
    e.done = (m_state == 2);
    chk("req_ready", 64'(req_ready), 64'(er));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("we", 64'(rf_write_enable), 64'(e.we));
    chk("addr", 64'(rf_in_addr), 64'(e.addr));
    chk("data", 64'(rf_in_data), 64'(e.data));
    chk("id", 64'(rf_grant_id), 64'(e.id));
    chk("busy", 64'(clear_busy), 64'(e.busy));
    chk("done", 64'(clear_done), 64'(e.done));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 64'(rf_write_enable), 64'd0);
    chk({tag, "_addr"}, 64'(rf_in_addr), 64'd0);
    chk({tag, "_data"}, 64'(rf_in_data), 64'd0);
    chk({tag, "_id"}, 64'(rf_grant_id), 64'd0);
    chk({tag, "_busy"}, 64'(clear_busy), 64'd0);
    chk({tag, "_done"}, 64'(clear_done), 64'd0);
`ifdef RF_ARB_STATS_EN
    chk({tag, "_stg"}, 64'(stat_grants), 64'd0);
    chk({tag, "_stc"}, 64'(stat_conflicts), 64'd0);
`endif
  endtask

  initial begin
    logic [NR-1:0] er;
    int seq_a [8] = '{2, 3, 0, 1, 2, 3, 0, 1};
    int seq_b [6] = '{3, 0, 1, 3, 0, 1};
    int strobes;
    bit done_seen;
    reset = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    hold = 1'b0; clear_start = 1'b0;
    model_reset();
    #12;
    check_zero("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Idle after reset
    for (int i = 0; i < 10; i++) cycle(er);

    // Single write from requester 1
    set_req(1, 1'b1, 5'd2, 32'd2222);
    cycle(er);
    chk("t2_ready", 64'(er), 64'h2);
    chk("t2_data", 64'(rf_in_data), 64'd2222);
    chk("t2_id", 64'(rf_grant_id), 64'd1);
    set_req(1, 1'b0, 5'd0, 32'd0);
    cycle(er);
    chk("t2_mem", 64'(rf_mem[2]), 64'd2222);

    // All four requesters continuously valid; pointer starts at 2 after the grant to 1
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(4 + i), DW'(100 + i));
    for (int i = 0; i < 8; i++) begin
      cycle(er);
      chk("t3_order", 64'(rf_grant_id), 64'(seq_a[i]));
    end
    set_req(2, 1'b0, 5'd6, 32'd102);
    for (int i = 0; i < 6; i++) begin
      cycle(er);
      chk("t3_drop", 64'(rf_grant_id), 64'(seq_b[i]));
    end
    req_valid = '0;
    cycle(er);

    // Hold freezes grants
    set_req(0, 1'b1, 5'd9, 32'h99);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle(er);
    hold = 1'b0;
    cycle(er);
    chk("t4_grant", 64'(er), 64'h1);
    set_req(0, 1'b1, 5'd2, 32'd5678);
    cycle(er);
    req_valid = '0;
    cycle(er);
    chk("t5_pre", 64'(rf_mem[2]), 64'd5678);

    // Clear with a request pending from requester 3
    set_req(3, 1'b1, 5'd12, 32'hABCD);
    clear_start = 1'b1;
    strobes = 0; done_seen = 0;
    cycle(er);
    chk("t5_prio", 64'(er), 64'h0);
    clear_start = 1'b0;
    for (int i = 0; i < 40 && req_valid[3]; i++) begin
      cycle(er);
      if (rf_write_enable && clear_busy) strobes++;
      if (clear_done) begin
        done_seen = 1;
        chk("t5_last", 64'(rf_in_addr), 64'd31);
      end
      if (er[3]) begin
        chk("t5_after", 64'(done_seen), 64'd1);
        req_valid[3] = 1'b0;
      end
    end
    chk("t5_pending", 64'(req_valid[3]), 64'd0);
    chk("t5_strobes", 64'(strobes), 64'd32);
    cycle(er);
    chk("t5_mem2", 64'(rf_mem[2]), 64'd0);
    chk("t5_mem12", 64'(rf_mem[12]), 64'hABCD);

    // Reset in the middle of a clear
    clear_start = 1'b1;
    cycle(er);
    clear_start = 1'b0;
    for (int i = 0; i < 40 && m_cnt < 10; i++) cycle(er);
    chk("t6_cnt", 64'(rf_in_addr), 64'd9);
    reset = 1'b0;
    #1;
    check_zero("t6_rst");
    model_reset();
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    cycle(er);
    clear_start = 1'b1;
    cycle(er);
    clear_start = 1'b0;
    cycle(er);
    chk("t6_restart", 64'(rf_in_addr), 64'd0);
    for (int i = 0; i < 34; i++) cycle(er);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
